// File: rtl/bios_loader_pkg.sv
// Shared types and constants for the BIOS loader.
package next186_pkg;

    localparam int BIOS_WORDS = 8192;
    localparam int BIOS_AW    = 13;

    // One FIFO entry: the word address travels with its data.
    typedef struct packed {
        logic [BIOS_AW-1:0] addr;
        logic [15:0]        data;
    } bios_word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } loader_state_t;

endpackage

// File: rtl/bios_loader_if.sv
// Bus bundle between hps_io download port, the loader and the BIOS sink.
interface bios_loader_if;
    import next186_pkg::*;

    logic               ioctl_download;
    logic [15:0]        ioctl_index;
    logic               ioctl_wr;
    logic [24:0]        ioctl_addr;
    logic [15:0]        ioctl_dout;
    logic               ioctl_wait;
    logic               bios_req;
    logic [BIOS_AW-1:0] bios_addr;
    logic [15:0]        bios_din;
    logic               bios_wr;
    logic               bios_loaded;
    logic               overrun;

    // Master drives the download stream and the sink's ready signal.
    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, bios_req,
        input  ioctl_wait, bios_addr, bios_din, bios_wr, bios_loaded, overrun
    );

    // Slave is the loader itself.
    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, bios_req,
        output ioctl_wait, bios_addr, bios_din, bios_wr, bios_loaded, overrun
    );

endinterface

// File: rtl/bios_loader_fifo.sv
// Synchronous single-clock FIFO of address/data pairs. Small depth, so the
// storage is read asynchronously (LUT RAM); the loader registers the output.
module bios_fifo
    import next186_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  bios_word_t               wr_data,
    output bios_word_t               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    bios_word_t      mem_reg [DEPTH];
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [PW:0]     count_reg;
    logic            do_push;
    logic            do_pop;

    // A push into a full FIFO is dropped even if a pop happens in the same cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge clk_sys) begin
        if (do_push && !flush) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush behaves like reset.
    always_ff @(posedge clk_sys) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rd_data = mem_reg[rd_ptr_reg];
    assign full    = (count_reg == (PW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;

endmodule

// File: rtl/bios_loader.sv
// Captures the BIOS image from the HPS download stream and replays it to the
// system as address/data write strobes, paced by bios_req.
module bios_loader
    import next186_pkg::*;
#(
    parameter int         DEPTH = 16,
    parameter logic [7:0] IDX   = 8'h00
) (
    input  logic          clk_sys,
    input  logic          reset,
    bios_loader_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    loader_state_t      state_reg;
    logic               dl_prev_reg;
    logic [13:0]        cnt_reg;
    logic [13:0]        cnt_next;
    logic               bios_wr_reg;
    logic [BIOS_AW-1:0] bios_addr_reg;
    logic [15:0]        bios_din_reg;
    logic               loaded_reg;
    logic               overrun_reg;

    logic               idx_match;
    logic               dl_rise;
    logic               dl_fall;
    logic               start_load;
    logic               wr_hit;
    logic               push;
    logic               pop;
    logic               at_limit;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    bios_word_t         fifo_wr_data;
    bios_word_t         fifo_rd_data;
    logic               unused_bits;

    assign unused_bits = ^{bus.ioctl_index[15:8], bus.ioctl_addr[0]};

    assign idx_match  = (bus.ioctl_index[7:0] == IDX);
    assign dl_rise    = bus.ioctl_download & ~dl_prev_reg & idx_match;
    assign dl_fall    = ~bus.ioctl_download & dl_prev_reg;
    assign start_load = dl_rise & ((state_reg == ST_IDLE) | (state_reg == ST_DONE));

    // Only in-window writes of the selected image during LOAD are taken.
    assign wr_hit = (state_reg == ST_LOAD) & bus.ioctl_download & bus.ioctl_wr &
                    idx_match & (bus.ioctl_addr[24:14] == 11'd0);
    assign push   = wr_hit & ~fifo_full;

    // Stop popping once the delivered count (including a strobe in flight)
    // reaches the image size, so the counter saturates instead of wrapping.
    assign at_limit = (cnt_reg == 14'(BIOS_WORDS)) |
                      ((cnt_reg == 14'(BIOS_WORDS - 1)) & bios_wr_reg);
    assign pop      = bus.bios_req & ~fifo_empty & ~at_limit & ~start_load;
    assign cnt_next = (bios_wr_reg && !(cnt_reg == 14'(BIOS_WORDS))) ? cnt_reg + 14'd1 : cnt_reg;

    assign fifo_wr_data.addr = bus.ioctl_addr[13:1];
    assign fifo_wr_data.data = bus.ioctl_dout;

    bios_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .flush   (start_load),
        .wr_data (fifo_wr_data),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Loader FSM with registered status flags; edge register tracks download
    // even during reset so a held download does not look like a new start.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            loaded_reg  <= 1'b0;
            overrun_reg <= 1'b0;
            dl_prev_reg <= bus.ioctl_download;
        end else begin
            dl_prev_reg <= bus.ioctl_download;
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start_load) begin
                        state_reg   <= ST_LOAD;
                        loaded_reg  <= 1'b0;
                        overrun_reg <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (wr_hit && fifo_full) overrun_reg <= 1'b1;
                    if (cnt_next == 14'(BIOS_WORDS)) begin
                        state_reg  <= ST_DONE;
                        loaded_reg <= 1'b1;
                    end else if (dl_fall) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_next == 14'(BIOS_WORDS) || fifo_empty) begin
                        state_reg  <= ST_DONE;
                        loaded_reg <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Output strobe, held address/data and the delivered-word counter.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt_reg       <= '0;
            bios_wr_reg   <= 1'b0;
            bios_addr_reg <= '0;
            bios_din_reg  <= '0;
        end else begin
            cnt_reg     <= start_load ? 14'd0 : cnt_next;
            bios_wr_reg <= pop;
            if (pop) begin
                bios_addr_reg <= fifo_rd_data.addr;
                bios_din_reg  <= fifo_rd_data.data;
            end
        end
    end

    assign bus.ioctl_wait  = (fifo_count >= CW'(DEPTH - 2));
    assign bus.bios_wr     = bios_wr_reg;
    assign bus.bios_addr   = bios_addr_reg;
    assign bus.bios_din    = bios_din_reg;
    assign bus.bios_loaded = loaded_reg;
    assign bus.overrun     = overrun_reg;

endmodule

// File: tb/tb_bios_loader.sv
// Directed-plus-random bench for bios_loader with a queue-based reference model.
module tb_bios_loader;
    import next186_pkg::*;

    localparam int          DEPTH = 16;
    localparam logic [15:0] KEY   = 16'hA5A5;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;

    bios_loader_if bif();

    bios_loader #(.DEPTH(DEPTH), .IDX(8'h00)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bif.slave)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobe_cnt = 0;
    int last_strobe_cyc = 0;
    bit model_load = 1'b0;
    bit model_ovr = 1'b0;
    bit rand_req = 1'b0;
    logic [28:0] exp_q[$];

    always @(posedge clk_sys) cyc++;

    // Every strobe must carry the oldest accepted word still owed to the sink.
    always @(negedge clk_sys) begin
        logic [28:0] expw;
        if (bif.bios_wr === 1'b1) begin
            strobe_cnt++;
            last_strobe_cyc = cyc;
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL strobe_unexpected observed addr=%h din=%h expected no strobe",
                       bif.bios_addr, bif.bios_din);
            end
            if (exp_q.size() > 0) begin
                expw = exp_q.pop_front();
                checks++;
                assert ({bif.bios_addr, bif.bios_din} === expw) else begin
                    errors++;
                    $error("FAIL strobe_word observed=%h expected=%h",
                           {bif.bios_addr, bif.bios_din}, expw);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
        if (rand_req) bif.bios_req = 1'($urandom_range(0, 1));
    endtask

    task automatic start_dl(input logic [7:0] idx);
        bif.ioctl_index    = {8'h00, idx};
        bif.ioctl_download = 1'b1;
        tick();
        tick();
        model_load = (idx == 8'h00);
        if (model_load) begin
            model_ovr = 1'b0;
            chk("start_overrun_clear", bif.overrun, 0);
            chk("start_loaded_clear", bif.bios_loaded, 0);
        end
    endtask

    task automatic end_dl();
        bif.ioctl_download = 1'b0;
        model_load = 1'b0;
        tick();
    endtask

    // One HPS write strobe; the model decides acceptance from the filter rules
    // and a FIFO that holds at most DEPTH words.
    task automatic wr_word(input logic [24:0] baddr, input logic [15:0] d, input bit honour);
        int n = 0;
        if (honour) begin
            while (bif.ioctl_wait === 1'b1 && n < 2000) begin
                tick();
                n++;
            end
            if (n >= 2000) chk("wait_release_bound", 32'(n), 0);
        end
        bif.ioctl_addr = baddr;
        bif.ioctl_dout = d;
        bif.ioctl_wr   = 1'b1;
        tick();
        bif.ioctl_wr   = 1'b0;
        if (model_load && bif.ioctl_index[7:0] == 8'h00 && baddr[24:14] == 11'd0) begin
            if (exp_q.size() < DEPTH) exp_q.push_back({baddr[13:1], d});
            else model_ovr = 1'b1;
        end
    endtask

    task automatic wait_loaded(input string tag, input bit check_latency);
        int n = 0;
        while (bif.bios_loaded !== 1'b1 && n < 20000) begin
            @(negedge clk_sys);
            n++;
        end
        chk({tag, "_loaded_seen"}, bif.bios_loaded, 1);
        if (check_latency) chk({tag, "_loaded_latency"}, 32'(cyc), 32'(last_strobe_cyc + 1));
        chk({tag, "_queue_drained"}, 32'(exp_q.size()), 0);
        tick();
    endtask

    initial begin
        bif.ioctl_download = 1'b0;
        bif.ioctl_index    = 16'h0000;
        bif.ioctl_wr       = 1'b0;
        bif.ioctl_addr     = '0;
        bif.ioctl_dout     = '0;
        bif.bios_req       = 1'b0;
        repeat (3) tick();

        // Reset values
        chk("rst_bios_wr", bif.bios_wr, 0);
        chk("rst_bios_addr", bif.bios_addr, 0);
        chk("rst_bios_din", bif.bios_din, 0);
        chk("rst_loaded", bif.bios_loaded, 0);
        chk("rst_overrun", bif.overrun, 0);
        chk("rst_wait", bif.ioctl_wait, 0);
        reset = 1'b0;
        tick();

        // Full 8192-word image with the sink always ready
        bif.bios_req = 1'b1;
        start_dl(8'h00);
        strobe_cnt = 0;
        for (int i = 0; i < BIOS_WORDS; i++) wr_word(25'(2 * i), 16'(i) ^ KEY, 1'b1);
        wait_loaded("full", 1'b1);
        chk("full_strobes", 32'(strobe_cnt), 32'(BIOS_WORDS));
        chk("full_overrun", bif.overrun, 0);
        end_dl();
        chk("full_loaded_sticky", bif.bios_loaded, 1);

        // Back-pressure honoured: wait rises at occupancy DEPTH-2, nothing lost
        bif.bios_req = 1'b0;
        start_dl(8'h00);
        strobe_cnt = 0;
        for (int i = 0; i < DEPTH - 2; i++) begin
            wr_word(25'(2 * i), 16'($urandom), 1'b0);
            chk("bp_wait_level", bif.ioctl_wait, ((i + 1) >= DEPTH - 2) ? 1 : 0);
        end
        bif.bios_req = 1'b1;
        for (int i = DEPTH - 2; i < 20; i++) wr_word(25'(2 * i), 16'($urandom), 1'b1);
        end_dl();
        wait_loaded("bp", 1'b1);
        chk("bp_strobes", 32'(strobe_cnt), 20);
        chk("bp_overrun", bif.overrun, model_ovr);

        // Back-pressure ignored: words past DEPTH are dropped, overrun sticks
        bif.bios_req = 1'b0;
        start_dl(8'h00);
        strobe_cnt = 0;
        for (int i = 0; i < 20; i++) wr_word(25'(2 * i), 16'($urandom), 1'b0);
        chk("ovr_set", bif.overrun, model_ovr);
        chk("ovr_wait_high", bif.ioctl_wait, 1);
        bif.bios_req = 1'b1;
        end_dl();
        wait_loaded("ovr", 1'b1);
        chk("ovr_strobes", 32'(strobe_cnt), DEPTH);
        chk("ovr_sticky", bif.overrun, model_ovr);

        // Simultaneous push and pop at occupancy 5 keeps occupancy at 5
        bif.bios_req = 1'b0;
        start_dl(8'h00);
        strobe_cnt = 0;
        for (int i = 0; i < 5; i++) wr_word(25'(2 * i), 16'($urandom), 1'b0);
        bif.bios_req = 1'b1;
        wr_word(25'(10), 16'($urandom), 1'b0);
        bif.bios_req = 1'b0;
        @(negedge clk_sys);
        #1;
        chk("pp_one_strobe", 32'(strobe_cnt), 1);
        for (int i = 0; i < 9; i++) begin
            wr_word(25'(12 + 2 * i), 16'($urandom), 1'b0);
            chk("pp_wait_level", bif.ioctl_wait, ((5 + i + 1) >= DEPTH - 2) ? 1 : 0);
        end
        bif.bios_req = 1'b1;
        end_dl();
        wait_loaded("pp", 1'b1);
        chk("pp_strobes", 32'(strobe_cnt), 15);

        // Short random-paced image of 100 words
        rand_req = 1'b1;
        start_dl(8'h00);
        strobe_cnt = 0;
        for (int i = 0; i < 100; i++) wr_word(25'(2 * i), 16'($urandom), 1'b1);
        rand_req = 1'b0;
        end_dl();
        bif.bios_req = 1'b1;
        wait_loaded("short", 1'b1);
        chk("short_strobes", 32'(strobe_cnt), 100);

        // Empty download still completes
        start_dl(8'h00);
        strobe_cnt = 0;
        end_dl();
        wait_loaded("empty", 1'b0);
        chk("empty_strobes", 32'(strobe_cnt), 0);

        // Foreign index and out-of-window address are ignored
        start_dl(8'h01);
        chk("flt_loaded_kept", bif.bios_loaded, 1);
        wr_word(25'h4000, 16'($urandom), 1'b1);
        wr_word(25'h0010, 16'($urandom), 1'b1);
        end_dl();
        repeat (4) tick();
        chk("flt_no_strobe", 32'(strobe_cnt), 0);
        chk("flt_loaded_still", bif.bios_loaded, 1);
        start_dl(8'h00);
        wr_word(25'h4000, 16'($urandom), 1'b1);
        wr_word(25'h0002, 16'($urandom), 1'b1);
        end_dl();
        wait_loaded("flt", 1'b1);
        chk("flt_strobes", 32'(strobe_cnt), 1);

        // Reset in the middle of a load aborts it
        start_dl(8'h00);
        strobe_cnt = 0;
        for (int i = 0; i < 3000; i++) wr_word(25'(2 * i), 16'($urandom), 1'b1);
        reset = 1'b1;
        tick();
        exp_q.delete();
        model_load = 1'b0;
        chk("mid_rst_bios_wr", bif.bios_wr, 0);
        chk("mid_rst_bios_addr", bif.bios_addr, 0);
        chk("mid_rst_bios_din", bif.bios_din, 0);
        chk("mid_rst_loaded", bif.bios_loaded, 0);
        chk("mid_rst_overrun", bif.overrun, 0);
        chk("mid_rst_wait", bif.ioctl_wait, 0);
        reset = 1'b0;
        tick();
        strobe_cnt = 0;
        for (int i = 0; i < 3; i++) wr_word(25'(2 * i), 16'($urandom), 1'b1);
        repeat (4) tick();
        chk("post_rst_idle_strobes", 32'(strobe_cnt), 0);
        chk("post_rst_idle_loaded", bif.bios_loaded, 0);
        end_dl();
        start_dl(8'h00);
        for (int i = 0; i < 10; i++) wr_word(25'(2 * i), 16'($urandom), 1'b1);
        end_dl();
        wait_loaded("restart", 1'b1);
        chk("restart_strobes", 32'(strobe_cnt), 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bios_loader.md
BIOS_LOADER -- requirements
Module: bios_loader

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in 16-bit words; power of two, minimum 4.
REQ-002 Parameter IDX, default 8'h00, ioctl_index[7:0] value that selects the BIOS image.
REQ-003 clk_sys  in  1  single block clock; one clock; all logic on posedge clk_sys.
REQ-004 reset  in  1  reset, synchronous and active-high.
REQ-005 ioctl_download  in  1  HPS download active.
REQ-006 ioctl_index  in  16  download index; only bits [7:0] are compared.
REQ-007 ioctl_wr  in  1  one-cycle strobe; ioctl_dout is valid in that cycle.
REQ-008 ioctl_addr  in  25  byte address; even-aligned in WIDE mode.
REQ-009 ioctl_dout  in  16  word data; [7:0] low byte, [15:8] high byte.
REQ-010 ioctl_wait  out  1  back-pressure to hps_io.
REQ-011 bios_req  in  1  system is ready to accept BIOS words.
REQ-012 bios_addr  out  13  BIOS word address.
REQ-013 bios_din  out  16  BIOS word data.
REQ-014 bios_wr  out  1  one-cycle write strobe qualifying bios_addr and bios_din.
REQ-015 bios_loaded  out  1  image fully delivered; level, sticky.
REQ-016 overrun  out  1  sticky flag: a word was dropped because the FIFO was full.

Function
REQ-017 A word is accepted only when ioctl_download, ioctl_wr and ioctl_index[7:0]==IDX are all high and ioctl_addr[24:14]==0; all other writes are ignored without side effects.
REQ-018 Each accepted word is pushed into the FIFO as {ioctl_addr[13:1], ioctl_dout}.
- No byte swap.
- The address travels with the data.
REQ-019 ioctl_wait is high whenever FIFO occupancy >= DEPTH-2, so that one in-flight strobe after wait rises is still absorbed.
REQ-020 If a push is attempted while the FIFO is full:
- the word is dropped;
- overrun is set;
- overrun stays set until the next download start or reset.
REQ-021 Pop rule: a pop occurs in any cycle where bios_req is high and the FIFO is not empty.
- In the following cycle, bios_wr=1 and bios_addr/bios_din hold the popped entry.
- Latency from pop to strobe is exactly 1 cycle.
- Maximum throughput is 1 word per cycle.
REQ-022 bios_wr is low in every cycle that does not follow a pop; bios_addr and bios_din hold their last value when bios_wr is low.
REQ-023 Simultaneous push and pop in one cycle leaves occupancy unchanged; both operations complete.
REQ-024 A delivered-word counter (14-bit) increments on each bios_wr.
REQ-025 State machine IDLE -> LOAD -> DRAIN -> DONE:
- IDLE: entered at reset.
- IDLE or DONE -> LOAD: on a rising edge of ioctl_download while ioctl_index[7:0]==IDX.
- LOAD -> DRAIN: on a falling edge of ioctl_download.
- DRAIN -> DONE: when the FIFO is empty and no bios_wr is pending.
- LOAD or DRAIN -> DONE: when the counter reaches 8192.
REQ-026 On entry to LOAD the block clears the FIFO, the counter, bios_loaded and overrun in the same cycle.
REQ-027 bios_loaded is 1 only in DONE; it drops in the cycle LOAD is entered.
REQ-028 Words arriving after the counter reaches 8192 are discarded; the counter saturates at 8192 and does not wrap.
REQ-029 A download with a non-matching index never changes state, FIFO, counter or outputs.
REQ-030 A download that ends with zero words delivered still reaches DONE.

Reset
REQ-031 Reset sets the following, overriding any simultaneous event:
- state=IDLE;
- FIFO empty;
- counter=0;
- bios_wr=0, bios_addr=0, bios_din=0;
- bios_loaded=0, overrun=0, ioctl_wait=0.
REQ-032 Reset asserted mid-LOAD aborts the load; after release the block stays in IDLE until a new download rising edge.

Structure
REQ-033 Package next186_pkg holds:
- BIOS_WORDS=8192;
- BIOS_AW=13;
- typedef bios_word_t (struct: 13-bit addr, 16-bit data);
- the loader state enum.
REQ-034 Sub-module bios_fifo holds the storage:
- synchronous single-clock FIFO of bios_word_t;
- parameter DEPTH;
- ports push, pop, flush, full, empty, count.
REQ-035 bios_loader contains only control logic, edge detection, the counter and output registers.

Verification
REQ-036 Full load: 8192 words with data=addr^16'hA5A5, bios_req held high -> 8192 bios_wr pulses with matching addr/data in order; bios_loaded=1 one cycle after the last strobe; overrun=0.
REQ-037 Back-pressure: bios_req=0 while 20 words are sent at 1 per cycle, DEPTH=16 -> ioctl_wait high at occupancy 14; with a bench that honours wait, no drop and overrun=0. With a bench that ignores wait, words beyond 16 are dropped and overrun=1.
REQ-038 Simultaneous push and pop: occupancy 5, push and pop in the same cycle -> occupancy stays 5; the strobe carries the oldest entry.
REQ-039 Short image: 100 words, then ioctl_download falls -> DRAIN, then DONE after the 100th strobe; counter=100.
REQ-040 Filtering: ioctl_index=8'h01 download, and a write at ioctl_addr=25'h4000 -> no push, no state change.
REQ-041 Reset at word 3000 -> all outputs at reset values next cycle; a new download restarts from addr 0.
